// File: rtl/candy_mem.sv
// candy_mem: memory-access stage between execute and candy_wb.
// Ports:
//   clk, rst (sync, active-low)
//   ex_valid/ex_ready handshake with ex_op, ex_alu_result, ex_mem_addr,
//     ex_store_data, ex_reg_addr from the execute stage
//   sram_re/sram_raddr read request, sram_rdata/sram_rvalid read response
//   wb_enable pulse with is_mem, result, sram_result_addr, reg_addr to candy_wb
//   mem_err pulse on load timeout or illegal op
module candy_mem #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  ex_op,
    input  logic [23:0] ex_alu_result,
    input  logic [16:0] ex_mem_addr,
    input  logic [23:0] ex_store_data,
    input  logic [3:0]  ex_reg_addr,
    output logic        sram_re,
    output logic [16:0] sram_raddr,
    input  logic [23:0] sram_rdata,
    input  logic        sram_rvalid,
    output logic        wb_enable,
    output logic        is_mem,
    output logic [23:0] result,
    output logic [16:0] sram_result_addr,
    output logic [3:0]  reg_addr,
    output logic        mem_err
);
    typedef enum logic {IDLE, READ_WAIT} state_t;
    localparam logic [7:0] WMAX = 8'(TIMEOUT - 1);
    state_t     state;
    logic [7:0] wcnt;
    logic [3:0] ld_reg;
    assign ex_ready = state == IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            wcnt             <= '0;
            ld_reg           <= '0;
            wb_enable        <= 1'b0;
            is_mem           <= 1'b0;
            result           <= '0;
            sram_result_addr <= '0;
            reg_addr         <= '0;
            sram_re          <= 1'b0;
            sram_raddr       <= '0;
            mem_err          <= 1'b0;
        end else begin
            wb_enable <= 1'b0;
            sram_re   <= 1'b0;
            mem_err   <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid) begin
                    case (ex_op)
                        2'b00: begin
                            wb_enable <= 1'b1;
                            is_mem    <= 1'b0;
                            result    <= ex_alu_result;
                            reg_addr  <= ex_reg_addr;
                        end
                        2'b01: begin
                            sram_re    <= 1'b1;
                            sram_raddr <= ex_mem_addr;
                            ld_reg     <= ex_reg_addr;
                            wcnt       <= '0;
                            state      <= READ_WAIT;
                        end
                        2'b10: begin
                            wb_enable        <= 1'b1;
                            is_mem           <= 1'b1;
                            result           <= ex_store_data;
                            sram_result_addr <= ex_mem_addr;
                        end
                        default: mem_err <= 1'b1;
                    endcase
                end
            end else if (sram_rvalid) begin
                // a strobe on the timeout edge still completes the load
                wb_enable <= 1'b1;
                is_mem    <= 1'b0;
                result    <= sram_rdata;
                reg_addr  <= ld_reg;
                state     <= IDLE;
            end else if (wcnt == WMAX) begin
                mem_err <= 1'b1;
                state   <= IDLE;
            end else begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_candy_mem.sv
// tb_candy_mem: directed self-checking bench for candy_mem.
module tb_candy_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [1:0]  ex_op = '0;
    logic [23:0] ex_alu_result = '0;
    logic [16:0] ex_mem_addr = '0;
    logic [23:0] ex_store_data = '0;
    logic [3:0]  ex_reg_addr = '0;
    logic        sram_re;
    logic [16:0] sram_raddr;
    logic [23:0] sram_rdata = '0;
    logic        sram_rvalid = 1'b0;
    logic        wb_enable;
    logic        is_mem;
    logic [23:0] result;
    logic [16:0] sram_result_addr;
    logic [3:0]  reg_addr;
    logic        mem_err;
    int checks = 0;
    int errors = 0;

    candy_mem #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_alu_result(ex_alu_result), .ex_mem_addr(ex_mem_addr),
        .ex_store_data(ex_store_data), .ex_reg_addr(ex_reg_addr),
        .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .sram_rvalid(sram_rvalid), .wb_enable(wb_enable), .is_mem(is_mem),
        .result(result), .sram_result_addr(sram_result_addr),
        .reg_addr(reg_addr), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [23:0] alu;
        logic [16:0] addr;
        logic [23:0] sdata;
        logic [3:0]  rd;
        logic        e_wb;
        logic        e_mem;
        logic [23:0] e_res;
        logic [16:0] e_sra;
        logic [3:0]  e_reg;
        logic        e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input logic [16:0] a, input logic [3:0] r, input int rv_at,
                            input logic [23:0] d, output int wb_c, output int err_c,
                            output int re_c, output int rdy_low);
        ex_valid = 1'b1;
        ex_op = 2'b01;
        ex_mem_addr = a;
        ex_reg_addr = r;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("load_raddr", 32'(sram_raddr), 32'(a));
        wb_c = -1;
        err_c = -1;
        re_c = 0;
        rdy_low = 0;
        for (int c = 0; c < 20; c++) begin
            re_c += int'(sram_re);
            rdy_low += int'(!ex_ready);
            if (wb_enable && wb_c < 0) wb_c = c;
            if (mem_err && err_c < 0) err_c = c;
            sram_rvalid = (c == rv_at);
            sram_rdata = d;
            @(negedge clk);
        end
        sram_rvalid = 1'b0;
    endtask

    initial begin
        int wb_c, err_c, re_c, rdy_low, bad;
        //             valid op     alu         addr    sdata       rd    wb mem res         sra    reg   err
        vecs[0] = '{1'b1, 2'b00, 24'h37c549, 17'd0,  24'h0,      4'h4, 1, 0, 24'h37c549, 17'd0,  4'h4, 0};
        vecs[1] = '{1'b1, 2'b00, 24'h000001, 17'd0,  24'h0,      4'h1, 1, 0, 24'h000001, 17'd0,  4'h1, 0};
        vecs[2] = '{1'b1, 2'b00, 24'h000002, 17'd0,  24'h0,      4'h2, 1, 0, 24'h000002, 17'd0,  4'h2, 0};
        vecs[3] = '{1'b1, 2'b00, 24'h000003, 17'd0,  24'h0,      4'h3, 1, 0, 24'h000003, 17'd0,  4'h3, 0};
        vecs[4] = '{1'b1, 2'b10, 24'h0,      17'd11, 24'h37c549, 4'h9, 1, 1, 24'h37c549, 17'd11, 4'h3, 0};
        vecs[5] = '{1'b0, 2'b00, 24'h0,      17'd0,  24'h0,      4'h0, 0, 1, 24'h37c549, 17'd11, 4'h3, 0};
        vecs[6] = '{1'b1, 2'b00, 24'haaaaaa, 17'd5,  24'h0,      4'h5, 1, 0, 24'haaaaaa, 17'd11, 4'h5, 0};
        vecs[7] = '{1'b1, 2'b11, 24'h123456, 17'd6,  24'h654321, 4'h6, 0, 0, 24'haaaaaa, 17'd11, 4'h5, 1};
        vecs[8] = '{1'b0, 2'b00, 24'h0,      17'd0,  24'h0,      4'h0, 0, 0, 24'haaaaaa, 17'd11, 4'h5, 0};

        rst = 1'b0;
        ex_valid = 1'b1;
        ex_op = 2'b00;
        ex_alu_result = 24'hffffff;
        ex_reg_addr = 4'hf;
        repeat (2) @(negedge clk);
        chk("rst_wb", 32'(wb_enable), 0);
        chk("rst_is_mem", 32'(is_mem), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_sra", 32'(sram_result_addr), 0);
        chk("rst_reg", 32'(reg_addr), 0);
        chk("rst_re", 32'(sram_re), 0);
        chk("rst_raddr", 32'(sram_raddr), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_ready", 32'(ex_ready), 1);
        ex_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            ex_valid = vecs[i].valid;
            ex_op = vecs[i].op;
            ex_alu_result = vecs[i].alu;
            ex_mem_addr = vecs[i].addr;
            ex_store_data = vecs[i].sdata;
            ex_reg_addr = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_wb", i), 32'(wb_enable), 32'(vecs[i].e_wb));
            chk($sformatf("v%0d_is_mem", i), 32'(is_mem), 32'(vecs[i].e_mem));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].e_res));
            chk($sformatf("v%0d_sra", i), 32'(sram_result_addr), 32'(vecs[i].e_sra));
            chk($sformatf("v%0d_reg", i), 32'(reg_addr), 32'(vecs[i].e_reg));
            chk($sformatf("v%0d_err", i), 32'(mem_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_ready", i), 32'(ex_ready), 1);
        end
        ex_valid = 1'b0;

        run_load(17'd20, 4'h7, 3, 24'h00abcd, wb_c, err_c, re_c, rdy_low);
        chk("load_wb_cycle", 32'(wb_c), 4);
        chk("load_no_err", 32'(err_c), 32'hffffffff);
        chk("load_re_count", 32'(re_c), 1);
        chk("load_ready_low", 32'(rdy_low), 4);
        chk("load_result", 32'(result), 32'h00abcd);
        chk("load_reg", 32'(reg_addr), 7);
        chk("load_is_mem", 32'(is_mem), 0);

        run_load(17'd33, 4'h2, 0, 24'h5a5a5a, wb_c, err_c, re_c, rdy_low);
        chk("zl_wb_cycle", 32'(wb_c), 1);
        chk("zl_ready_low", 32'(rdy_low), 1);
        chk("zl_result", 32'(result), 32'h5a5a5a);
        chk("zl_reg", 32'(reg_addr), 2);

        run_load(17'd44, 4'h8, -1, 24'h0, wb_c, err_c, re_c, rdy_low);
        chk("to_err_cycle", 32'(err_c), 4);
        chk("to_no_wb", 32'(wb_c), 32'hffffffff);
        chk("to_ready_low", 32'(rdy_low), 4);
        chk("to_result_held", 32'(result), 32'h5a5a5a);

        sram_rvalid = 1'b1;
        sram_rdata = 24'h999999;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            bad += int'(wb_enable) + int'(mem_err) + int'(sram_re);
        end
        sram_rvalid = 1'b0;
        chk("stray_ignored", 32'(bad), 0);
        chk("stray_result", 32'(result), 32'h5a5a5a);

        ex_valid = 1'b1;
        ex_op = 2'b01;
        ex_mem_addr = 17'd77;
        ex_reg_addr = 4'hc;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("ml_re", 32'(sram_re), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("ml_ready", 32'(ex_ready), 1);
        chk("ml_raddr", 32'(sram_raddr), 0);
        sram_rvalid = 1'b1;
        sram_rdata = 24'h777777;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sram_rvalid = 1'b0;
            bad += int'(wb_enable) + int'(mem_err);
        end
        chk("ml_silent", 32'(bad), 0);
        chk("ml_result", 32'(result), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/candy_mem.md
# candy_mem

Memory-access stage of the candy pipeline, directly upstream of `candy_wb`. It accepts one instruction per handshake from the execute stage. ALU results and stores pass straight through. Loads issue a read to the data SRAM and wait a variable number of cycles for the data. Each completed instruction is presented to `candy_wb` as a one-cycle `wb_enable` pulse, together with `is_mem`, `result`, `sram_result_addr` and `reg_addr`.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles a load may wait for `sram_rvalid` before it is aborted. Legal range is 2..255.

Ports:
- `clk`, in, 1: single clock; everything is sampled on its rising edge.
- `rst`, in, 1: reset. It is synchronous and active-low (`RstEnable` = 1'b0).
- `ex_valid`, in, 1: the execute stage presents an instruction.
- `ex_ready`, out, 1: the stage can accept an instruction this cycle. Defined as `state==IDLE`, combinational.
- `ex_op`, in, 2: 2'b00 ALU, 2'b01 LOAD, 2'b10 STORE, 2'b11 illegal.
- `ex_alu_result`, in, 24: ALU result, used by ALU ops.
- `ex_mem_addr`, in, 17: SRAM address, used by LOAD and STORE.
- `ex_store_data`, in, 24: data to store, used by STORE.
- `ex_reg_addr`, in, 4: destination register, used by ALU and LOAD.
- `sram_re`, out, 1: SRAM read request, a one-cycle pulse.
- `sram_raddr`, out, 17: SRAM read address. Held stable while a load is waiting.
- `sram_rdata`, in, 24: SRAM read data, valid when `sram_rvalid` is high.
- `sram_rvalid`, in, 1: read-data strobe.
- `wb_enable`, out, 1: one-cycle pulse; the write-back fields below are valid.
- `is_mem`, out, 1: 1 means `candy_wb` writes SRAM; 0 means it writes the register file.
- `result`, out, 24: data for write-back.
- `sram_result_addr`, out, 17: SRAM write address, meaningful when `is_mem`=1.
- `reg_addr`, out, 4: register write address, meaningful when `is_mem`=0.
- `mem_err`, out, 1: one-cycle pulse when a load times out or an illegal op is accepted.

## Operation
- The FSM has two states: IDLE and READ_WAIT. A wait counter `wcnt` (8 bits) counts cycles in READ_WAIT.
- Acceptance happens on a rising edge where `ex_valid & ex_ready` is true.
- ALU accepted:
  - `wb_enable`←1, `is_mem`←0, `result`←`ex_alu_result`, `reg_addr`←`ex_reg_addr`.
  - `sram_result_addr` keeps its previous value.
  - The FSM stays in IDLE.
- STORE accepted:
  - `wb_enable`←1, `is_mem`←1, `result`←`ex_store_data`, `sram_result_addr`←`ex_mem_addr`.
  - `reg_addr` keeps its previous value.
  - The FSM stays in IDLE.
- LOAD accepted:
  - `sram_re`←1, `sram_raddr`←`ex_mem_addr`.
  - The destination register is latched internally.
  - `wcnt`←0, state←READ_WAIT.
- Illegal op accepted: `mem_err`←1, nothing is written back, the FSM stays in IDLE.
- READ_WAIT, on each edge:
  - If `sram_rvalid`=1:
    - `wb_enable`←1, `is_mem`←0, `result`←`sram_rdata`, `reg_addr`←latched destination.
    - State←IDLE.
  - Else if `wcnt`==`TIMEOUT`-1: `mem_err`←1, state←IDLE, no write-back.
  - Else: `wcnt`←`wcnt`+1.
- `sram_rvalid` is ignored in IDLE. A stray or late strobe has no effect.
- `wb_enable`, `sram_re` and `mem_err` return to 0 on the edge after they are set, unless they are set again on that edge.
- `result`, `is_mem`, `sram_result_addr` and `reg_addr` hold their values between pulses.
- Reset (`rst`=0 sampled at an edge):
  - State←IDLE, `wcnt`←0.
  - Every output register←0: `wb_enable`, `is_mem`, `result`, `sram_result_addr`, `reg_addr`, `sram_re`, `sram_raddr`, `mem_err`.
  - Reset applied mid-load aborts the load silently: no `mem_err`, no write-back. A strobe arriving after reset is ignored.

## Timing
- ALU and STORE have 1-cycle latency: accepted at edge N, `wb_enable` is high during cycle N→N+1.
- Back-to-back ALU/STORE ops sustain one instruction per cycle, so `wb_enable` stays high for consecutive cycles.
- LOAD:
  - Accepted at edge N. `sram_re` is high during cycle N→N+1 and `ex_ready` goes low.
  - With `sram_rvalid` high in that same cycle (zero-latency SRAM), the write-back pulse occurs in cycle N+1→N+2.
  - With `sram_rvalid` first high in cycle N+k→N+k+1, `wb_enable` is high in cycle N+k+1→N+k+2.
  - `ex_ready` returns high in the same cycle as `wb_enable`. A new instruction can be accepted in that cycle.
- Timeout: with no strobe, `mem_err` is high in cycle N+`TIMEOUT`→N+`TIMEOUT`+1 and `ex_ready` is high again in that cycle.
- A strobe sampled on the timeout edge wins over the timeout: the load writes back and `mem_err` stays 0.
- Outputs are registered. The only combinational output is `ex_ready`.

## Test plan
- **Reset**
  - Stimulus: hold `rst`=0 for 2 cycles with `ex_valid`=1.
  - Required: every output is 0 and `ex_ready`=1.
- **ALU pass-through**
  - Stimulus: ALU with result 24'h37c549 and reg 4'h4.
  - Required: the next cycle shows `wb_enable`=1, `is_mem`=0, `result`=24'h37c549, `reg_addr`=4.
  - Stimulus: 3 back-to-back ALU ops.
  - Required: `wb_enable` high for 3 consecutive cycles.
- **STORE**
  - Stimulus: STORE with addr 17'd11 and data 24'h37c549.
  - Required: a one-cycle `wb_enable` with `is_mem`=1, `sram_result_addr`=11, `result`=24'h37c549.
- **LOAD**
  - Stimulus: LOAD from addr 17'd20 with reg 4'h7; `sram_rvalid` arrives 3 cycles after `sram_re` with data 24'h00abcd.
  - Required: `sram_re` pulses once with `sram_raddr`=20, `ex_ready`=0 for 4 cycles, then `wb_enable`=1 with `result`=24'h00abcd and `reg_addr`=7.
- **Timeout**
  - Stimulus: `TIMEOUT`=4, LOAD, no strobe.
  - Required: `mem_err` pulses 4 cycles after acceptance and there is no `wb_enable`.
  - Stimulus: a strobe arriving afterwards.
  - Required: it is ignored.
- **Reset mid-load and illegal op**
  - Stimulus: assert `rst` during READ_WAIT, then supply `sram_rvalid`.
  - Required: no `wb_enable` and no `mem_err`.
  - Stimulus: `ex_op`=2'b11.
  - Required: a `mem_err` pulse and no `wb_enable`.
